// File: rtl/aes_rs232_pkg.sv
// aes_rs232_pkg: shared FSM state type, RAM map constants and base-address check
// for the AES result readback path.
package aes_rs232_pkg;

    localparam int unsigned ADDR_W        = 7;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BLK_STRIDE    = 10;
    localparam int unsigned FLAG_OFS      = 5;
    localparam int unsigned WORDS_PER_BLK = 4;
    localparam int unsigned MAX_BASE      = 115;

    localparam logic [DATA_W-1:0] DONE_FLAG  = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] CLEAR_FLAG = 32'h0000_0000;

    typedef enum logic [3:0] {
        IDLE,
        POLL_REQ,
        POLL_CHK,
        RD_REQ,
        RD_WAIT,
        TX_LOAD,
        TX_RUN,
        CLR,
        FIN
    } rdr_state_t;

    // A block base must sit on the 10-word grid at offset 5 and leave room for B+5.
    function automatic logic base_valid(input logic [ADDR_W-1:0] b);
        return ((b % ADDR_W'(BLK_STRIDE)) == ADDR_W'(FLAG_OFS)) && (b <= ADDR_W'(MAX_BASE));
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser, one byte per load, LSB first, idle high.
// ready is high while idle and also during the final cycle of the stop bit,
// i.e. it means "a load presented now is accepted at the next edge".
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned LAST_BIT = 9;

    logic          active;
    logic          active_nxt;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_nxt;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_nxt;
    logic [8:0]    shreg;
    logic [8:0]    sh_nxt;
    logic          tx_nxt;
    logic          ready_nxt;

    // Bit timing and shift: start bit on load, then data[0..7], then stop bit.
    always_comb begin
        active_nxt = active;
        bit_nxt    = bit_cnt;
        clk_nxt    = clk_cnt;
        sh_nxt     = shreg;
        tx_nxt     = tx;
        if (load && ready) begin
            active_nxt = 1'b1;
            bit_nxt    = '0;
            clk_nxt    = '0;
            sh_nxt     = {1'b1, data};
            tx_nxt     = 1'b0;
        end else if (active) begin
            if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                clk_nxt = '0;
                if (bit_cnt == 4'(LAST_BIT)) begin
                    active_nxt = 1'b0;
                    tx_nxt     = 1'b1;
                end else begin
                    tx_nxt  = shreg[0];
                    sh_nxt  = {1'b1, shreg[8:1]};
                    bit_nxt = bit_cnt + 4'd1;
                end
            end else begin
                clk_nxt = clk_cnt + CW'(1);
            end
        end
        ready_nxt = !active_nxt ||
                    ((bit_nxt == 4'(LAST_BIT)) && (clk_nxt == CW'(CLKS_PER_BIT - 1)));
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
        end else begin
            active  <= active_nxt;
            bit_cnt <= bit_nxt;
            clk_cnt <= clk_nxt;
            shreg   <= sh_nxt;
            tx      <= tx_nxt;
            ready   <= ready_nxt;
        end
    end

endmodule

// File: rtl/aes_result_reader.sv
// aes_result_reader: waits for the AES done flag at B+5, reads the ciphertext words
// B+4..B+1 and streams them out over an 8N1 UART, most-significant byte first.
// Optional macro AES_RDR_CLR_FLAG_EN: clear the flag word (write 0 to B+5) after the
// last byte so the same block slot can be reused.
module aes_result_reader
    import aes_rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned POLL_MAX     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_action,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned PCW = $clog2(POLL_MAX + 1);

    rdr_state_t        state;
    rdr_state_t        state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_nxt;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_nxt;
    logic [1:0]        word_idx;
    logic [1:0]        widx_nxt;
    logic [1:0]        byte_idx;
    logic [1:0]        bidx_nxt;
    logic [PCW-1:0]    poll_cnt;
    logic [PCW-1:0]    poll_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              en_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              error_nxt;
    logic              load_c;
    logic              tx_ready;

    // Next-state logic plus registered-output decode from the next state.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        word_nxt  = word_q;
        widx_nxt  = word_idx;
        bidx_nxt  = byte_idx;
        poll_nxt  = poll_cnt;
        load_c    = 1'b0;
        error_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (base_valid(base_addr)) begin
                        base_nxt  = base_addr;
                        poll_nxt  = '0;
                        state_nxt = POLL_REQ;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            POLL_REQ: state_nxt = POLL_CHK;
            POLL_CHK: begin
                if (ram_rdata == DONE_FLAG) begin
                    widx_nxt  = 2'(WORDS_PER_BLK - 1);
                    state_nxt = RD_REQ;
                end else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    poll_nxt  = poll_cnt + PCW'(1);
                    state_nxt = POLL_REQ;
                end
            end
            RD_REQ: state_nxt = RD_WAIT;
            RD_WAIT: begin
                word_nxt  = ram_rdata;
                bidx_nxt  = '0;
                state_nxt = TX_LOAD;
            end
            TX_LOAD: begin
                load_c    = 1'b1;
                word_nxt  = {word_q[DATA_W-9:0], 8'h00};
                state_nxt = TX_RUN;
            end
            TX_RUN: begin
                if (tx_ready) begin
                    if (byte_idx == 2'd3) begin
                        if (word_idx == 2'd0) begin
`ifdef AES_RDR_CLR_FLAG_EN
                            state_nxt = CLR;
`else
                            state_nxt = FIN;
`endif
                        end else begin
                            widx_nxt  = word_idx - 2'd1;
                            state_nxt = RD_REQ;
                        end
                    end else begin
                        bidx_nxt  = byte_idx + 2'd1;
                        state_nxt = TX_LOAD;
                    end
                end
            end
`ifdef AES_RDR_CLR_FLAG_EN
            CLR: state_nxt = FIN;
`endif
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            POLL_REQ, CLR: addr_nxt = base_nxt + ADDR_W'(FLAG_OFS);
            RD_REQ:        addr_nxt = base_nxt + ADDR_W'(widx_nxt) + ADDR_W'(1);
            default:       addr_nxt = '0;
        endcase
        en_nxt   = (state_nxt == POLL_REQ) || (state_nxt == RD_REQ) || (state_nxt == CLR);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            word_q   <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            poll_cnt <= '0;
            ram_addr <= '0;
            ram_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            base_q   <= base_nxt;
            word_q   <= word_nxt;
            word_idx <= widx_nxt;
            byte_idx <= bidx_nxt;
            poll_cnt <= poll_nxt;
            ram_addr <= addr_nxt;
            ram_en   <= en_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
        end
    end

`ifdef AES_RDR_CLR_FLAG_EN
    // Write strobe for the flag clear; the only write this block ever issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_action <= 1'b0;
        end else begin
            ram_action <= (state_nxt == CLR);
        end
    end
`else
    assign ram_action = 1'b0;
`endif

    // Only value ever written is the cleared flag.
    assign ram_wdata = CLEAR_FLAG;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .data (word_q[DATA_W-1:DATA_W-8]),
        .tx   (tx),
        .ready(tx_ready)
    );

endmodule

// File: tb/tb_aes_result_reader.sv
// tb_aes_result_reader: scoreboard bench with a RAM model, UART receiver and access monitor.
module tb_aes_result_reader;

    localparam int unsigned C    = 4;
    localparam int unsigned PMAX = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  base_addr;
    logic [6:0]  ram_addr;
    logic        ram_en;
    logic        ram_action;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        tx;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    aes_result_reader #(.CLKS_PER_BIT(C), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_action(ram_action),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx(tx),
        .busy(busy), .done(done), .error(error)
    );

    // RAM model: synchronous read, plus a side port standing in for the AES core.
    logic [31:0] mem [128];
    logic        aes_wr;
    logic [6:0]  aes_addr;
    logic [31:0] aes_data;
    always @(posedge clk) begin
        if (aes_wr) mem[aes_addr] <= aes_data;
        if (ram_en && ram_action) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_action) ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp_bytes[$];
    logic [7:0] exp_acc[$];
    logic [6:0] cur_b = '0;
    int done_cnt = 0, err_cnt = 0, busy_cyc = 0, poll_cnt = 0, acc_cnt = 0, rx_started = 0;

    // Pulse/access monitor: polls of B+5 are counted, other accesses are scoreboarded.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (done)  done_cnt++;
            if (error) err_cnt++;
            if (busy)  busy_cyc++;
            if (ram_en) begin
                acc_cnt++;
                if (!ram_action && ram_addr == cur_b + 7'd5) begin
                    poll_cnt++;
                end else if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ram_access_extra: got act=%b addr=%0d, none expected", ram_action, ram_addr);
                end else begin
                    e = exp_acc.pop_front();
                    check("ram_access", 32'({ram_action, ram_addr}), 32'(e));
                end
            end
        end
    end

    // UART receiver: mid-bit sampling, frame checks, byte gap check inside a word.
    initial begin
        int t0, last_t, rx_idx;
        bit abort;
        logic sb0, sb1;
        logic [7:0] rb, e;
        rx_idx = 0;
        last_t = 0;
        forever begin
            @(negedge clk);
            if (!busy) rx_idx = 0;
            if (tx === 1'b0 && !rst) begin
                t0 = cyc;
                abort = 1'b0;
                rx_started++;
                if (rx_idx % 4 != 0) check("byte_gap", 32'(t0 - last_t), 32'(10 * C + 1));
                last_t = t0;
                rx_idx++;
                repeat (C / 2) begin @(negedge clk); if (rst) abort = 1'b1; end
                sb0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) begin @(negedge clk); if (rst) abort = 1'b1; end
                    rb[i] = tx;
                end
                repeat (C) begin @(negedge clk); if (rst) abort = 1'b1; end
                sb1 = tx;
                if (!abort) begin
                    check("start_bit", 32'(sb0), 32'd0);
                    check("stop_bit", 32'(sb1), 32'd1);
                    if (exp_bytes.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_byte_extra: got %h, none expected", rb);
                    end else begin
                        e = exp_bytes.pop_front();
                        check("tx_byte", 32'(rb), 32'(e));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic [6:0] a, input logic [31:0] d);
        aes_wr = 1'b1; aes_addr = a; aes_data = d;
        @(posedge clk); #1;
        aes_wr = 1'b0;
    endtask

    task automatic pulse_start(input logic [6:0] b);
        base_addr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        for (int i = 0; i < 3000 && rx_started < target; i++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Queue expectations for one block, run it and check the end-of-block state.
    task automatic push_block(input logic [6:0] b, input logic [31:0] w[4]);
        for (int k = 3; k >= 0; k--) begin
            exp_acc.push_back({1'b0, 7'(b + 7'(k) + 7'd1)});
            for (int j = 3; j >= 0; j--) exp_bytes.push_back(8'(w[k] >> (8 * j)));
        end
`ifdef AES_RDR_CLR_FLAG_EN
        exp_acc.push_back({1'b1, 7'(b + 7'd5)});
`endif
    endtask

    task automatic run_block(input logic [6:0] b, input logic [31:0] w[4], input int delay,
                             input bit poke, input int min_polls);
        int d0, e0, p0, r0;
        cur_b = b;
        for (int k = 0; k < 4; k++) ram_write(7'(b + 7'(k) + 7'd1), w[k]);
        ram_write(7'(b + 7'd5), (delay == 0) ? 32'hFFFF_FFFF : 32'h0);
        push_block(b, w);
        d0 = done_cnt; e0 = err_cnt; p0 = poll_cnt; r0 = rx_started;
        pulse_start(b);
        if (delay > 0) begin
            tick(delay - 1);
            ram_write(7'(b + 7'd5), 32'hFFFF_FFFF);
        end
        if (poke) begin
            wait_rx(r0 + 3);
            pulse_start(7'($urandom_range(0, 127)));
        end
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        tick(2);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("err_pulses", 32'(err_cnt - e0), 32'd0);
        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("acc_left", 32'(exp_acc.size()), 32'd0);
        if (delay == 0) check("polls", 32'(poll_cnt - p0), 32'd1);
        else check("polls_min", 32'((poll_cnt - p0) >= min_polls), 32'd1);
`ifdef AES_RDR_CLR_FLAG_EN
        check("flag_after", mem[7'(b + 7'd5)], 32'h0);
`else
        check("flag_after", mem[7'(b + 7'd5)], 32'hFFFF_FFFF);
`endif
        exp_bytes.delete();
        exp_acc.delete();
    endtask

    task automatic bad_start(input logic [6:0] b);
        int a0, b0, e0;
        a0 = acc_cnt; b0 = busy_cyc; e0 = err_cnt;
        pulse_start(b);
        @(negedge clk);
        check("err_pulse_t1", 32'(error), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("err_pulse_end", 32'(error), 32'd0);
        tick(3);
        check("err_no_ram", 32'(acc_cnt - a0), 32'd0);
        check("err_no_busy", 32'(busy_cyc - b0), 32'd0);
        check("err_count", 32'(err_cnt - e0), 32'd1);
    endtask

    initial begin
        logic [31:0] w[4];
        logic [6:0]  b;
        int a0, p0, e0, d0, r0;
        rst = 1'b1; start = 1'b0; base_addr = '0; aes_wr = 1'b0; aes_addr = '0; aes_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_action", 32'(ram_action), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // Known block at B=5: tx must carry 0F 0E ... 01 00.
        w[0] = 32'h0302_0100; w[1] = 32'h0706_0504; w[2] = 32'h0B0A_0908; w[3] = 32'h0F0E_0D0C;
        run_block(7'd5, w, 0, 1'b0, 1);

        // Flag appears 50 cycles after start.
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        run_block(7'd5, w, 50, 1'b0, 2);

        // Top valid base.
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        run_block(7'd115, w, 0, 1'b0, 1);

        // Random blocks, some with a stray start mid-transfer.
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            b = 7'(10 * $urandom_range(0, 11) + 5);
            run_block(b, w, (n % 2 == 0) ? 0 : int'($urandom_range(1, 40)), n[0], 1);
        end

        // Invalid bases.
        bad_start(7'd10);
        bad_start(7'd125);
        for (int n = 0; n < 3; n++) begin
            do b = 7'($urandom_range(0, 127)); while (b % 10 == 5 && b <= 115);
            bad_start(b);
        end

        // Poll timeout.
        cur_b = 7'd15;
        ram_write(7'd20, 32'h0);
        a0 = acc_cnt; p0 = poll_cnt; e0 = err_cnt; d0 = done_cnt;
        pulse_start(7'd15);
        for (int i = 0; i < 4 * PMAX + 20 && err_cnt == e0; i++) @(negedge clk);
        tick(2);
        check("timeout_polls", 32'(poll_cnt - p0), 32'(PMAX));
        check("timeout_reads", 32'(acc_cnt - a0), 32'(PMAX));
        check("timeout_err", 32'(err_cnt - e0), 32'd1);
        check("timeout_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);

        // Reset during byte 7, then a clean full block.
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        cur_b = 7'd25;
        for (int k = 0; k < 4; k++) ram_write(7'(26 + k), w[k]);
        ram_write(7'd30, 32'hFFFF_FFFF);
        push_block(7'd25, w);
        r0 = rx_started;
        pulse_start(7'd25);
        wait_rx(r0 + 7);
        check("rx_progress", 32'((rx_started - r0) >= 7), 32'd1);
        tick(2 * C);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ram_en", 32'(ram_en), 32'd0);
        exp_bytes.delete();
        exp_acc.delete();
        tick(60);
        check("abort_flag_kept", mem[7'd30], 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        run_block(7'd25, w, 0, 1'b0, 1);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
